// File: rtl/cronometro_pkg.sv
// Shared types and digit limits for the stopwatch / countdown digit chains.
package cronometro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] DEC_MAX = 4'd5;

  // Saturate a preset digit to the largest value its position can hold.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] v, input logic [3:0] m);
    return (v > m) ? m : v;
  endfunction

endpackage

// File: rtl/bcd_digito_down.sv
// One BCD down-counting digit: wraps from 0 to max_val and raises a borrow to the next digit.
module bcd_digito_down (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  input  logic [3:0] max_val,
  output logic [3:0] digit,
  output logic       borrow_out
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_val;
    end else if (dec_en) begin
      digit <= (digit == 4'd0) ? max_val : digit - 4'd1;
    end
  end

  assign borrow_out = dec_en && (digit == 4'd0);

endmodule

// File: rtl/cuenta_regresiva.sv
// BCD countdown timer (up to 59.99 s): FSM, 1/100 s prescaler, preset clamping and zero detect.
module cuenta_regresiva
  import cronometro_pkg::*;
#(
  parameter int DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] pre_decenas,
  input  logic [3:0] pre_unidades,
  input  logic [3:0] pre_decimas,
  input  logic [3:0] pre_centesimas,
  output logic [3:0] decenas,
  output logic [3:0] unidadesSegundo,
  output logic [3:0] decimas,
  output logic [3:0] centesimas,
  output logic       running,
  output logic       done,
  output logic [1:0] state_dbg
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic          is_zero;
  logic          going_zero;
  logic          running_d, done_d;
  logic          b_cent, b_decim, b_unid, b_dec;

  // A pause or load in the wrap cycle suppresses the tick.
  assign tick = (state_q == RUN) && !load && !pause && (presc_q == PMAX);

  assign is_zero = (decenas == 4'd0) && (unidadesSegundo == 4'd0) &&
                   (decimas == 4'd0) && (centesimas == 4'd0);

  assign going_zero = tick && (decenas == 4'd0) && (unidadesSegundo == 4'd0) &&
                      (decimas == 4'd0) && (centesimas == 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start && !is_zero) state_d = RUN;
        RUN:     if (pause) state_d = PAUSE;
                 else if (going_zero) state_d = DONE;
        PAUSE:   if (start && !pause) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    running_d = (state_d == RUN);
    done_d    = (state_q == RUN) && (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      running <= running_d;
      done    <= done_d;
    end
  end

  // Prescaler only advances in RUN; it keeps its phase across PAUSE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (load) begin
      presc_q <= '0;
    end else if (state_q == RUN && !pause) begin
      presc_q <= (presc_q == PMAX) ? '0 : presc_q + 1'b1;
    end
  end

  assign state_dbg = state_q;

  bcd_digito_down u_centesimas (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (clamp_bcd(pre_centesimas, BCD_MAX)),
    .dec_en     (tick),
    .max_val    (BCD_MAX),
    .digit      (centesimas),
    .borrow_out (b_cent)
  );

  bcd_digito_down u_decimas (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (clamp_bcd(pre_decimas, BCD_MAX)),
    .dec_en     (b_cent),
    .max_val    (BCD_MAX),
    .digit      (decimas),
    .borrow_out (b_decim)
  );

  bcd_digito_down u_unidades (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (clamp_bcd(pre_unidades, BCD_MAX)),
    .dec_en     (b_decim),
    .max_val    (BCD_MAX),
    .digit      (unidadesSegundo),
    .borrow_out (b_unid)
  );

  // The top digit never borrows past 00.00; going_zero stops the chain first.
  bcd_digito_down u_decenas (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (clamp_bcd(pre_decenas, DEC_MAX)),
    .dec_en     (b_unid),
    .max_val    (DEC_MAX),
    .digit      (decenas),
    .borrow_out (b_dec)
  );

  logic unused_borrow;
  assign unused_borrow = b_dec;

endmodule

// File: doc/cuenta_regresiva.md
# cuenta_regresiva

BCD countdown timer, the down-counting counterpart of the stopwatch digit chain (centésimas → décimas → unidades → decenas de segundo). Loads a preset time of up to 59.99 s, decrements it once per 1/100 s with digit borrows, and stops at 00.00 with a one-cycle `done` pulse. Its digit outputs feed the same 7-segment display path as the stopwatch.

## Interface
- `DIV`, default 500000: clock cycles per 1/100 s. 50 MHz gives 100 Hz. Must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, **active-low** reset.
- `load` in 1: load preset digits, then go to IDLE.
- `start` in 1: start or resume the countdown.
- `pause` in 1: freeze the countdown.
- `pre_decenas` in 4: preset tens of seconds (BCD).
- `pre_unidades` in 4: preset units of seconds (BCD).
- `pre_decimas` in 4: preset tenths (BCD).
- `pre_centesimas` in 4: preset hundredths (BCD).
- `decenas`, `unidadesSegundo`, `decimas`, `centesimas` out 4 each: current remaining time (BCD).
- `running` out 1: high while in RUN.
- `done` out 1: one-cycle pulse when the count reaches 00.00.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset (`rst`=0): state IDLE; all digits 0; prescaler 0; `running`=0; `done`=0. Takes effect immediately, without a clock edge.
- Input priority each cycle: reset > `load` > `pause` > `start`.
- `load` is accepted in any state:
  - digits ← preset, clamped: `pre_decenas` > 5 → 5; any other preset digit > 9 → 9;
  - prescaler ← 0; state → IDLE.
- IDLE:
  - `start` with nonzero digits → RUN;
  - `start` with all digits 0 → stay in IDLE, no `done`.
- RUN:
  - the prescaler counts 0 … DIV-1 and wraps; the wrap cycle is a tick;
  - on a tick the 4-digit chain decrements by one hundredth;
  - each digit at 0 becomes its max (9, or 5 for `decenas`) and borrows from the next digit up;
  - if the decremented value is 00.00 → DONE, and `done`=1 for that single cycle.
- RUN with `pause` → PAUSE. The prescaler holds its value and no decrement happens, even if that cycle would have been a tick.
- PAUSE:
  - `start` → RUN; the prescaler resumes from its held value;
  - `pause` and `start` together → stay in PAUSE.
- DONE: digits hold 00.00; `start` and `pause` are ignored; only `load` or reset leave DONE.
- `running` is 1 only in RUN.

## Timing
- All outputs are registered.
- First decrement happens DIV cycles after the cycle in which `start` is sampled in IDLE.
- Preset P hundredths reaches 00.00 exactly P·DIV cycles after start, excluding paused cycles.
- `done` rises on the same clock edge on which the digits become 00.00, and lasts exactly 1 cycle.
- A `load` sampled at edge k: digits show the clamped preset after edge k, and `running`=0.
- Tick coinciding with `load`: `load` wins and no decrement is applied.

## Structure
- Shared package `cronometro_pkg` holds:
  - the state enum {IDLE, RUN, PAUSE, DONE};
  - the constants `BCD_MAX`=9 and `DEC_MAX`=5.
- Sub-module `bcd_digito_down`, instantiated 4 times:
  - ports: `clk`, `rst`, `load`, `load_val`, `dec_en`, `max_val`, `digit`, `borrow_out`;
  - `borrow_out` = `dec_en` && `digit`==0;
  - each digit's `borrow_out` drives the next higher digit's `dec_en`.
- The top level holds the FSM, the prescaler (width `$clog2(DIV)`), the zero detect and the preset clamping.

## Test plan
All scenarios use `DIV`=4.
- **Reset:** drive `rst`=0 mid-RUN between clock edges → digits 0, `running`=0, `done`=0 immediately; state IDLE.
- **Basic countdown:** load 0,0,1,0, then `start` → after 4 cycles 0,0,0,9; after 40 cycles 0,0,0,0 with `done`=1 for exactly 1 cycle; `running` falls on the same edge.
- **Borrow chain:** load 1,0,0,0, then `start` → first tick gives 0,9,9,9.
- **Pause/resume:** `pause` 2 cycles after a tick, hold 20 cycles → digits unchanged. On `start`, the next tick comes 2 cycles later (prescaler preserved). `pause` and `start` together keep PAUSE.
- **Load mid-run:** load 2,5,0,0 during RUN → IDLE, digits 2,5,0,0, `running`=0, no decrement that cycle. Load while in DONE → IDLE.
- **Clamp and zero start:** load 7,C,F,A → 5,9,9,9. Load 0,0,0,0, then `start` → remains IDLE and `done` never asserts. `start` in DONE is ignored.
